seg_scan_driver: RTL and testbench

Time-multiplexed driver for the board's two 4-digit seven-segment banks, instantiated inside each function module (M0..M5) to produce the OUT_SEG0*/OUT_SEG1* signals that the top level multiplexes to the pins. A module loads eight glyph codes plus decimal-point and blink masks through a valid/ready handshake. The block double-buffers them, commits only at frame boundaries so no frame mixes old and new digits, and scans both banks in parallel with registered outputs.

---
 rtl/seg_pkg.sv | 36 +++
 rtl/seg_glyph_rom.sv | 43 ++++
 rtl/seg_scan_driver.sv | 177 +++++++++++++++++
 tb/tb_seg_scan_driver.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// seg_pkg: shared widths, glyph codes and the display buffer type
// for the seven-segment scan driver and its glyph ROM.
package seg_pkg;

  localparam int GW   = 5;
  localparam int SEGW = 7;
  localparam int NDIG = 8;

  typedef logic [GW-1:0]   glyph_t;
  typedef logic [SEGW-1:0] seg_t;

  localparam glyph_t GLY_BLANK = 5'd16;
  localparam glyph_t GLY_MINUS = 5'd17;
  localparam glyph_t GLY_H     = 5'd18;
  localparam glyph_t GLY_L     = 5'd19;
  localparam glyph_t GLY_P     = 5'd20;
  localparam glyph_t GLY_U     = 5'd21;
  localparam glyph_t GLY_R     = 5'd22;
  localparam glyph_t GLY_O     = 5'd23;
  localparam glyph_t GLY_N     = 5'd24;
  localparam glyph_t GLY_T     = 5'd25;

  // One complete display image: glyphs, decimal points, blink mask.
  typedef struct packed {
    glyph_t [NDIG-1:0] gly;
    logic [NDIG-1:0]   dp;
    logic [NDIG-1:0]   blink;
  } seg_buf_t;

  localparam seg_buf_t BUF_RST = '{
    gly:   {NDIG{GLY_BLANK}},
    dp:    '0,
    blink: '0
  };

endpackage

// File: rtl/seg_glyph_rom.sv
// seg_glyph_rom: glyph code to segment pattern lookup.
// Ports: code_i glyph code in, seg_o {g,f,e,d,c,b,a} active-high out.
module seg_glyph_rom
  import seg_pkg::*;
(
  input  logic [GW-1:0]   code_i,
  output logic [SEGW-1:0] seg_o
);

  always_comb begin
    seg_o = '0;
    case (code_i)
      5'd0:      seg_o = 7'h3F;
      5'd1:      seg_o = 7'h06;
      5'd2:      seg_o = 7'h5B;
      5'd3:      seg_o = 7'h4F;
      5'd4:      seg_o = 7'h66;
      5'd5:      seg_o = 7'h6D;
      5'd6:      seg_o = 7'h7D;
      5'd7:      seg_o = 7'h07;
      5'd8:      seg_o = 7'h7F;
      5'd9:      seg_o = 7'h6F;
      5'd10:     seg_o = 7'h77;
      5'd11:     seg_o = 7'h7C;
      5'd12:     seg_o = 7'h39;
      5'd13:     seg_o = 7'h5E;
      5'd14:     seg_o = 7'h79;
      5'd15:     seg_o = 7'h71;
      GLY_BLANK: seg_o = 7'h00;
      GLY_MINUS: seg_o = 7'h40;
      GLY_H:     seg_o = 7'h76;
      GLY_L:     seg_o = 7'h38;
      GLY_P:     seg_o = 7'h73;
      GLY_U:     seg_o = 7'h3E;
      GLY_R:     seg_o = 7'h50;
      GLY_O:     seg_o = 7'h5C;
      GLY_N:     seg_o = 7'h54;
      GLY_T:     seg_o = 7'h78;
      default:   seg_o = 7'h00;
    endcase
  end

endmodule

// File: rtl/seg_scan_driver.sv
// seg_scan_driver: double-buffered, frame-synchronous scan driver
// for two 4-digit seven-segment banks.
// Ports: IN_CLK/IN_RST clock and sync reset; ENABLE gates display;
// LOAD_* valid/ready image load; OUT_SEG{0,1}{DATA,SELE,DP}
// registered bank drives; OUT_FRAME first-cycle-of-frame pulse.
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int unsigned SCAN_DIV  = 100_000,
  parameter int unsigned BLINK_DIV = 50_000_000
)(
  input  logic               IN_CLK,
  input  logic               IN_RST,
  input  logic               ENABLE,
  input  logic               LOAD_VALID,
  output logic               LOAD_READY,
  input  logic [NDIG*GW-1:0] LOAD_GLYPH,
  input  logic [NDIG-1:0]    LOAD_DP,
  input  logic [NDIG-1:0]    LOAD_BLINK,
  output logic [SEGW-1:0]    OUT_SEG0DATA,
  output logic [SEGW-1:0]    OUT_SEG1DATA,
  output logic [3:0]         OUT_SEG0SELE,
  output logic [3:0]         OUT_SEG1SELE,
  output logic               OUT_SEG0DP,
  output logic               OUT_SEG1DP,
  output logic               OUT_FRAME
);

  localparam int SW =
    (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int BW =
    (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  logic          run_q;
  logic [SW-1:0] slot_q, slot_d;
  logic [BW-1:0] bcnt_q, bcnt_d;
  logic [1:0]    idx_q, idx_d;
  logic          vis_q, vis_d;
  seg_buf_t      act_q, act_d;
  seg_buf_t      shd_q, shd_d;
  logic          pend_q, pend_d;

  logic [SEGW-1:0] seg0_q, seg1_q;
  logic [3:0]      sel0_q, sel1_q;
  logic            dp0_q, dp1_q;
  logic            frame_q;

  logic tick, slot_tc, bnd, xfer, frame_d;
  logic [2:0]      dig0, dig1;
  logic [SEGW-1:0] rom0, rom1;
  logic            hide0, hide1;

  assign LOAD_READY = !pend_q && !IN_RST;
  assign xfer = LOAD_VALID && LOAD_READY;

  // Counters only run once the first display cycle has been
  // issued, so every digit slot is SCAN_DIV output cycles long.
  assign tick = ENABLE && run_q;
  assign slot_tc =
    tick && (slot_q == SW'(SCAN_DIV - 1));
  assign bnd = slot_tc && (idx_q == 2'd3);
  assign frame_d = !run_q || bnd;

  always_comb begin
    slot_d = slot_q;
    idx_d  = idx_q;
    bcnt_d = bcnt_q;
    vis_d  = vis_q;
    if (!ENABLE) begin
      slot_d = '0;
      idx_d  = '0;
      bcnt_d = '0;
      vis_d  = 1'b1;
    end else if (run_q) begin
      if (slot_tc) begin
        slot_d = '0;
        idx_d  = idx_q + 2'd1;
      end else begin
        slot_d = slot_q + SW'(1);
      end
      if (bcnt_q == BW'(BLINK_DIV - 1)) begin
        bcnt_d = '0;
        vis_d  = !vis_q;
      end else begin
        bcnt_d = bcnt_q + BW'(1);
      end
    end
  end

  // Accept needs !pend_q and commit needs pend_q, so the two
  // never touch the same image in one cycle.
  always_comb begin
    act_d  = act_q;
    shd_d  = shd_q;
    pend_d = pend_q;
    if (bnd && pend_q) begin
      act_d  = shd_q;
      pend_d = 1'b0;
    end
    if (xfer) begin
      shd_d  = {LOAD_GLYPH, LOAD_DP, LOAD_BLINK};
      pend_d = 1'b1;
    end
  end

  // Outputs are built from next state so index, digit and
  // freshly committed image all land on the same edge.
  assign dig0 = {1'b1, idx_d};
  assign dig1 = {1'b0, idx_d};
  assign hide0 = !vis_d && act_d.blink[dig0];
  assign hide1 = !vis_d && act_d.blink[dig1];

  seg_glyph_rom u_rom0 (
    .code_i (act_d.gly[dig0]),
    .seg_o  (rom0)
  );

  seg_glyph_rom u_rom1 (
    .code_i (act_d.gly[dig1]),
    .seg_o  (rom1)
  );

  always_ff @(posedge IN_CLK) begin
    if (IN_RST) begin
      run_q   <= 1'b0;
      slot_q  <= '0;
      idx_q   <= '0;
      bcnt_q  <= '0;
      vis_q   <= 1'b1;
      act_q   <= BUF_RST;
      shd_q   <= '0;
      pend_q  <= 1'b0;
      seg0_q  <= '0;
      seg1_q  <= '0;
      sel0_q  <= '0;
      sel1_q  <= '0;
      dp0_q   <= 1'b0;
      dp1_q   <= 1'b0;
      frame_q <= 1'b0;
    end else begin
      run_q  <= ENABLE;
      slot_q <= slot_d;
      idx_q  <= idx_d;
      bcnt_q <= bcnt_d;
      vis_q  <= vis_d;
      act_q  <= act_d;
      shd_q  <= shd_d;
      pend_q <= pend_d;
      if (ENABLE) begin
        seg0_q  <= hide0 ? '0 : rom0;
        seg1_q  <= hide1 ? '0 : rom1;
        sel0_q  <= 4'b0001 << idx_d;
        sel1_q  <= 4'b0001 << idx_d;
        dp0_q   <= !hide0 && act_d.dp[dig0];
        dp1_q   <= !hide1 && act_d.dp[dig1];
        frame_q <= frame_d;
      end else begin
        seg0_q  <= '0;
        seg1_q  <= '0;
        sel0_q  <= '0;
        sel1_q  <= '0;
        dp0_q   <= 1'b0;
        dp1_q   <= 1'b0;
        frame_q <= 1'b0;
      end
    end
  end

  assign OUT_SEG0DATA = seg0_q;
  assign OUT_SEG1DATA = seg1_q;
  assign OUT_SEG0SELE = sel0_q;
  assign OUT_SEG1SELE = sel1_q;
  assign OUT_SEG0DP   = dp0_q;
  assign OUT_SEG1DP   = dp1_q;
  assign OUT_FRAME    = frame_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// tb_seg_scan_driver: directed loads with a frame scoreboard;
// expected frames are queued by stimulus and checked by a monitor.
module tb_seg_scan_driver;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        lv;
  logic        lr;
  logic [39:0] lg;
  logic [7:0]  ldp;
  logic [7:0]  lbl;
  logic [6:0]  s0, s1;
  logic [3:0]  e0, e1;
  logic        p0, p1, fr;

  always #5 clk = ~clk;

  seg_scan_driver #(
    .SCAN_DIV  (4),
    .BLINK_DIV (64)
  ) dut (
    .IN_CLK       (clk),
    .IN_RST       (rst),
    .ENABLE       (en),
    .LOAD_VALID   (lv),
    .LOAD_READY   (lr),
    .LOAD_GLYPH   (lg),
    .LOAD_DP      (ldp),
    .LOAD_BLINK   (lbl),
    .OUT_SEG0DATA (s0),
    .OUT_SEG1DATA (s1),
    .OUT_SEG0SELE (e0),
    .OUT_SEG1SELE (e1),
    .OUT_SEG0DP   (p0),
    .OUT_SEG1DP   (p1),
    .OUT_FRAME    (fr)
  );

  typedef struct {
    int                fno;
    logic [3:0][6:0]   s0;
    logic [3:0][6:0]   s1;
    logic [3:0]        d0;
    logic [3:0]        d1;
  } exp_t;

  exp_t q[$];
  int n_pass = 0;
  int n_tot  = 0;
  int frame_no = 0;
  int cyc = 0;

  // payloads: glyph 7..0, then hand-derived patterns idx3..idx0
  localparam logic [39:0] G_B =
    {5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8};
  localparam logic [27:0] B_S0 = {7'h06, 7'h5B, 7'h4F, 7'h66};
  localparam logic [27:0] B_S1 = {7'h6D, 7'h7D, 7'h07, 7'h7F};

  localparam logic [39:0] G_P =
    {5'd14, 5'd15, 5'd0, 5'd9, 5'd10, 5'd11, 5'd12, 5'd13};
  localparam logic [27:0] P_S0 = {7'h79, 7'h71, 7'h3F, 7'h6F};
  localparam logic [27:0] P_S1 = {7'h77, 7'h7C, 7'h39, 7'h5E};

  localparam logic [39:0] G_Q =
    {5'd17, 5'd16, 5'd31, 5'd26, 5'd1, 5'd0, 5'd2, 5'd4};
  localparam logic [27:0] Q_S0 = {7'h40, 7'h00, 7'h00, 7'h00};
  localparam logic [27:0] Q_S1 = {7'h06, 7'h3F, 7'h5B, 7'h66};

  localparam logic [39:0] G_D = {8{5'd8}};
  localparam logic [27:0] D_S  = {4{7'h7F}};

  localparam logic [39:0] G_E =
    {5'd18, 5'd19, 5'd20, 5'd21, 5'd23, 5'd24, 5'd25, 5'd22};
  localparam logic [27:0] E_S0  = {7'h76, 7'h38, 7'h73, 7'h3E};
  localparam logic [27:0] E_S1  = {7'h5C, 7'h54, 7'h78, 7'h50};
  localparam logic [27:0] E_S1H = {7'h5C, 7'h54, 7'h78, 7'h00};

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] req);
    n_tot++;
    if (act === req) n_pass++;
    else $display("FAIL %s actual=%h required=%h", nm, act, req);
  endtask

  task automatic push(input int f,
                      input logic [27:0] a, input logic [27:0] b,
                      input logic [3:0] c, input logic [3:0] d);
    exp_t e;
    e.fno = f; e.s0 = a; e.s1 = b; e.d0 = c; e.d1 = d;
    q.push_back(e);
  endtask

  function automatic logic [24:0] outs();
    return {s0, s1, e0, e1, p0, p1, fr};
  endfunction

  // Monitor: one snapshot per digit slot, compare on frame end.
  logic [3:0][6:0] o_s0, o_s1;
  logic [3:0]      o_d0, o_d1;
  logic            sel_ok;

  always @(negedge clk) begin : mon
    int i;
    exp_t e;
    if (fr) begin
      frame_no++;
      cyc = 0;
      sel_ok = 1'b1;
    end else begin
      cyc++;
    end
    if (cyc % 4 == 0 && cyc <= 12) begin
      i = cyc / 4;
      o_s0[i] = s0;
      o_s1[i] = s1;
      o_d0[i] = p0;
      o_d1[i] = p1;
      if (e0 !== (4'b0001 << i) || e1 !== (4'b0001 << i))
        sel_ok = 1'b0;
      if (cyc == 12) begin
        while (q.size() > 0 && q[0].fno < frame_no) begin
          n_tot++;
          $display("FAIL frame%0d_missed actual=none required=frame",
                   q[0].fno);
          void'(q.pop_front());
        end
        if (q.size() > 0 && q[0].fno == frame_no) begin
          e = q.pop_front();
          chk($sformatf("frame%0d_img", frame_no),
              {8'h0, o_s0, o_s1, o_d0, o_d1},
              {8'h0, e.s0, e.s1, e.d0, e.d1});
          chk($sformatf("frame%0d_sele", frame_no),
              64'(sel_ok), 64'd1);
        end
      end
    end
  end

  task automatic wait_frame(input int n);
    int k = 0;
    while (frame_no < n && k < 400) begin
      @(negedge clk); #1; k++;
    end
    if (frame_no < n) begin
      n_tot++;
      $display("FAIL wait_frame actual=%0d required=%0d",
               frame_no, n);
    end
  endtask

  task automatic do_load(input logic [39:0] g,
                         input logic [7:0] d,
                         input logic [7:0] b);
    int k = 0;
    lg = g; ldp = d; lbl = b; lv = 1'b1;
    while (!lr && k < 200) begin
      @(negedge clk); #1; k++;
    end
    if (!lr) begin
      n_tot++;
      $display("FAIL load_wait actual=0 required=1");
    end
    @(posedge clk); #1;
    lv = 1'b0;
    @(negedge clk); #1;
    chk("ready_fall", 64'(lr), 64'd0);
  endtask

  initial begin
    logic rdy;
    int nx;
    logic sel;
    rst = 1'b1; en = 1'b1; lv = 1'b0;
    lg = '0; ldp = '0; lbl = '0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_outs", 64'(outs()), 64'd0);
    chk("rst_ready", 64'(lr), 64'd0);
    push(1, '0, '0, 4'h0, 4'h0);
    push(2, B_S0, B_S1, 4'b0001, 4'h0);
    rst = 1'b0;
    #1;
    chk("ready_after_rst", 64'(lr), 64'd1);

    wait_frame(1);
    do_load(G_B, 8'h10, 8'h00);
    wait_frame(2);
    chk("ready_rise_b", 64'(lr), 64'd1);

    // continuous valid, alternating P/Q payloads
    wait_frame(3);
    push(3, B_S0, B_S1, 4'b0001, 4'h0);
    push(4, P_S0, P_S1, 4'h0, 4'h0);
    push(5, Q_S0, Q_S1, 4'h0, 4'hF);
    push(6, P_S0, P_S1, 4'h0, 4'h0);
    push(7, Q_S0, Q_S1, 4'h0, 4'hF);
    lg = G_P; ldp = 8'h00; lbl = 8'h00; lv = 1'b1;
    nx = 0; sel = 1'b0;
    for (int c = 0; c < 64; c++) begin
      rdy = lr;
      @(posedge clk); #1;
      if (rdy) begin
        nx++;
        sel = !sel;
        lg  = sel ? G_Q : G_P;
        ldp = sel ? 8'h0F : 8'h00;
      end
      @(negedge clk); #1;
    end
    lv = 1'b0;
    chk("xfer_count", 64'(nx), 64'd4);

    // load lands on the boundary edge
    wait_frame(7);
    push(8, Q_S0, Q_S1, 4'h0, 4'hF);
    push(9, D_S, D_S, 4'hF, 4'hF);
    repeat (15) @(negedge clk);
    #1;
    do_load(G_D, 8'hFF, 8'h00);

    // blink on digit 0
    wait_frame(9);
    chk("ready_rise_d", 64'(lr), 64'd1);
    push(10, E_S0, E_S1, 4'b1000, 4'b0001);
    push(12, E_S0, E_S1, 4'b1000, 4'b0001);
    push(13, E_S0, E_S1H, 4'b1000, 4'b0000);
    push(16, E_S0, E_S1H, 4'b1000, 4'b0000);
    do_load(G_E, 8'h81, 8'h01);

    // disable mid-frame, load while disabled
    wait_frame(17);
    repeat (5) @(negedge clk);
    #1;
    en = 1'b0;
    @(negedge clk); #1;
    chk("disable_outs", 64'(outs()), 64'd0);
    do_load(G_B, 8'h10, 8'h00);
    repeat (6) @(negedge clk);
    #1;
    chk("disabled_outs", 64'(outs()), 64'd0);
    push(18, E_S0, E_S1, 4'b1000, 4'b0001);
    push(19, B_S0, B_S1, 4'b0001, 4'h0);
    en = 1'b1;
    @(negedge clk); #1;
    chk("reenable_frame", 64'(fr), 64'd1);
    chk("reenable_sele", 64'(e0), 64'd1);

    // reset with a load pending
    wait_frame(20);
    do_load(G_D, 8'hFF, 8'h00);
    repeat (2) @(negedge clk);
    #1;
    push(21, '0, '0, 4'h0, 4'h0);
    push(22, '0, '0, 4'h0, 4'h0);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("rst2_outs", 64'(outs()), 64'd0);
    chk("rst2_ready", 64'(lr), 64'd0);
    rst = 1'b0;
    #1;
    chk("rst2_ready_after", 64'(lr), 64'd1);

    wait_frame(22);
    for (int k = 0; k < 40 && q.size() > 0; k++)
      @(negedge clk);
    #1;
    if (q.size() > 0) begin
      n_tot++;
      $display("FAIL leftover actual=%0d required=0", q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
